design_reset_sequencer: RTL and testbench
=========================================

DESIGN_RESET_SEQUENCER -- requirements
Module: design_reset_sequencer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, meaning the Wishbone base of a 16-byte register window.
REQ-002 SHALL have parameter HOLD_DEFAULT, default 16, meaning the reset value of the HOLD register in clock cycles.
REQ-003 SHALL have port wb_clk_i, input, 1, the single clock.
REQ-004 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have ports wbs_cyc_i, wbs_stb_i and wbs_we_i, input, 1 each, Wishbone classic control.
REQ-006 SHALL have ports wbs_adr_i and wbs_dat_i, input, 32 each, Wishbone address and write data.
REQ-007 SHALL have ports wbs_ack_o (output, 1) and wbs_dat_o (output, 32), Wishbone acknowledge and read data.
REQ-008 SHALL have port design_rst_n, output, 3, per-design active-low resets: bit0 scrapcpu, bit1 vliw, bit2 z80.
REQ-009 SHALL have port active_sel, output, 2, the design currently driving the pads (3 = none).
REQ-010 SHALL have port custom_settings, output, 32, the SETTINGS register value.
REQ-011 SHALL have port busy, output, 1, high in any state other than RUN or OFF.

Function
REQ-012 SHALL decode a hit as cyc&stb with wbs_adr_i[31:4]==BASE_ADDR[31:4]; wbs_adr_i[3:2] selects 0 CTRL, 1 SETTINGS, 2 STATUS, 3 HOLD.
REQ-013 SHALL assert wbs_ack_o for exactly one cycle, the cycle after a hit, and hold it low the following cycle even if stb stays high.
REQ-014 SHALL return 0 on wbs_dat_o for non-hit cycles and for unmapped bits.
REQ-015 SHALL define CTRL as [1:0] req_sel and [2] enable, read/write.
REQ-016 SHALL define SETTINGS as 32-bit read/write, driving custom_settings directly.
REQ-017 SHALL define STATUS as read-only: [2:0] state, [4:3] active_sel, [15:8] counter[7:0]; writes to STATUS SHALL be acked and ignored.
REQ-018 SHALL define HOLD as read/write, 8 bits; a written value of 0 SHALL be treated as 1.
REQ-019 SHALL implement FSM states OFF, DRAIN, SWITCH, RELEASE and RUN.
REQ-020 SHALL set design_rst_n to 3'b000 in every state except RUN; in RUN only bit active_sel SHALL be 1.
REQ-021 OFF: if enable=1 and req_sel<3, the FSM SHALL go to SWITCH.
REQ-022 RUN: if enable=0, or req_sel differs from active_sel, the FSM SHALL go to DRAIN, loading counter with HOLD and dropping all resets that same cycle.
REQ-023 DRAIN: counter SHALL decrement each cycle; at counter==1 the FSM SHALL go to SWITCH.
REQ-024 SWITCH: one cycle; active_sel SHALL take req_sel, or 3 if enable=0 or req_sel==3; the FSM SHALL then go to OFF if active_sel is 3, else to RELEASE with counter loaded from HOLD.
REQ-025 RELEASE: counter SHALL decrement each cycle; at counter==1 the FSM SHALL go to RUN, with the selected reset rising on the first RUN cycle.
REQ-026 CTRL writes during DRAIN or RELEASE SHALL update the register immediately and be sampled only in SWITCH or RUN (no abort mid-hold).
REQ-027 Latency: from the CTRL write ack in RUN to the new design's reset release SHALL be 2*HOLD+2 cycles.
REQ-028 req_sel==3 with enable=1 SHALL behave as disable.

Reset
REQ-029 On rst_n low, asynchronously: CTRL=0, SETTINGS=0, HOLD=HOLD_DEFAULT, state=OFF, active_sel=3, counter=0, design_rst_n=0, wbs_ack_o=0, wbs_dat_o=0, busy=0.
REQ-030 A reset asserted mid-sequence SHALL force OFF with no residual counter state.

Structure
REQ-031 SHALL place the register offsets, FSM state encoding and design index constants (SCRAP=0, VLIW=1, Z80=2, NONE=3) in a shared package, design_mux_pkg.
REQ-032 SHALL use one sub-module, wb_reg_slave, for the Wishbone decode/ack/readback; the FSM and counter SHALL stay in the top module.

Verification
REQ-033 Reset -> design_rst_n=000, active_sel=3, HOLD reads 16, STATUS state=OFF.
REQ-034 CTRL write 0x6 (enable, sel 2) from OFF -> SWITCH, then 16 RELEASE cycles, then design_rst_n=100 and active_sel=2.
REQ-035 In RUN with sel 2, CTRL write 0x4 (sel 0) with HOLD=4 -> resets 000 for 4+1+4 cycles, then design_rst_n=001; total 10 cycles after the ack.
REQ-036 HOLD write 0, then a switch -> one-cycle DRAIN and one-cycle RELEASE.
REQ-037 SETTINGS write 0xDEADBEEF -> custom_settings=0xDEADBEEF, readback matches, single-cycle ack; a write to an address outside the window -> no ack.
REQ-038 rst_n pulsed low during RELEASE -> immediate OFF, all resets 0, registers at their reset values.

Source files
------------

// File: rtl/design_mux_pkg.sv
// design_mux_pkg: register offsets, FSM states and design indices shared by the reset sequencer
package design_mux_pkg;
  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_SETTINGS = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_HOLD = 2'd3;
  localparam logic [1:0] SCRAP = 2'd0;
  localparam logic [1:0] VLIW = 2'd1;
  localparam logic [1:0] Z80 = 2'd2;
  localparam logic [1:0] NONE = 2'd3;
  typedef enum logic [2:0] {ST_OFF, ST_DRAIN, ST_SWITCH, ST_RELEASE, ST_RUN} state_t;
  function automatic logic [2:0] rst_mask(input logic [1:0] sel);
    return {sel == Z80, sel == VLIW, sel == SCRAP};
  endfunction
endpackage

// File: rtl/design_reset_sequencer_if.sv
// design_reset_sequencer_if: Wishbone classic slave bundle
interface design_reset_sequencer_if;
  logic cyc;
  logic stb;
  logic we;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic ack;
  logic [31:0] dat_r;
  modport master(output cyc, stb, we, adr, dat_w, input ack, dat_r);
  modport slave(input cyc, stb, we, adr, dat_w, output ack, dat_r);
endinterface

// File: rtl/design_reset_sequencer_wb_reg_slave.sv
// wb_reg_slave: Wishbone decode, single-cycle ack, CTRL/SETTINGS/HOLD registers and readback
module wb_reg_slave
  import design_mux_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int HOLD_DEFAULT = 16
) (
  input logic clk,
  input logic rst_n,
  design_reset_sequencer_if.slave bus,
  input logic [15:0] status,
  output logic [2:0] ctrl,
  output logic [31:0] settings,
  output logic [7:0] hold
);
  logic hit;
  logic take;
  logic [1:0] idx;
  logic [31:0] rdata;
  logic unused_adr;
  // a hit is taken only when no ack is pending, so a held strobe sees ack every other cycle
  always_comb begin
    hit = bus.cyc & bus.stb & (bus.adr[31:4] == BASE_ADDR[31:4]);
    take = hit & ~bus.ack;
    idx = bus.adr[3:2];
    unused_adr = ^bus.adr[1:0];
    rdata = idx == REG_CTRL ? {29'd0, ctrl} :
            idx == REG_SETTINGS ? settings :
            idx == REG_STATUS ? {16'd0, status} : {24'd0, hold};
  end
  // registered ack/readback and register writes; HOLD of zero is stored as one
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.ack <= 1'b0;
      bus.dat_r <= '0;
      ctrl <= '0;
      settings <= '0;
      hold <= 8'(HOLD_DEFAULT);
    end else begin
      bus.ack <= take;
      bus.dat_r <= take ? rdata : '0;
      if (take && bus.we) begin
        if (idx == REG_CTRL) ctrl <= bus.dat_w[2:0];
        if (idx == REG_SETTINGS) settings <= bus.dat_w;
        if (idx == REG_HOLD) hold <= bus.dat_w[7:0] == 8'd0 ? 8'd1 : bus.dat_w[7:0];
      end
    end
endmodule

// File: rtl/design_reset_sequencer.sv
// design_reset_sequencer: hands the pads between designs with drain/release reset holds
module design_reset_sequencer
  import design_mux_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int HOLD_DEFAULT = 16
) (
  input logic wb_clk_i,
  input logic rst_n,
  input logic wbs_cyc_i,
  input logic wbs_stb_i,
  input logic wbs_we_i,
  input logic [31:0] wbs_adr_i,
  input logic [31:0] wbs_dat_i,
  output logic wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [2:0] design_rst_n,
  output logic [1:0] active_sel,
  output logic [31:0] custom_settings,
  output logic busy
);
  design_reset_sequencer_if wb();
  state_t state, state_n;
  logic [7:0] cnt, cnt_n, hold;
  logic [1:0] sel_n, want;
  logic [2:0] ctrl;
  assign wb.cyc = wbs_cyc_i;
  assign wb.stb = wbs_stb_i;
  assign wb.we = wbs_we_i;
  assign wb.adr = wbs_adr_i;
  assign wb.dat_w = wbs_dat_i;
  assign wbs_ack_o = wb.ack;
  assign wbs_dat_o = wb.dat_r;
  wb_reg_slave #(.BASE_ADDR(BASE_ADDR), .HOLD_DEFAULT(HOLD_DEFAULT)) u_regs (
    .clk(wb_clk_i),
    .rst_n(rst_n),
    .bus(wb),
    .status({cnt, 3'b000, active_sel, state}),
    .ctrl(ctrl),
    .settings(custom_settings),
    .hold(hold)
  );
  // requested design, with disable and req_sel==3 both meaning none
  assign want = ctrl[2] && ctrl[1:0] != NONE ? ctrl[1:0] : NONE;
  // next state, hold counter and selection; CTRL is only looked at in OFF, RUN and SWITCH
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sel_n = active_sel;
    case (state)
      ST_OFF: state_n = want != NONE ? ST_SWITCH : ST_OFF;
      ST_RUN: if (want != active_sel) begin
        state_n = ST_DRAIN;
        cnt_n = hold;
      end
      ST_DRAIN: begin
        cnt_n = cnt - 8'd1;
        state_n = cnt == 8'd1 ? ST_SWITCH : ST_DRAIN;
      end
      ST_SWITCH: begin
        sel_n = want;
        state_n = want == NONE ? ST_OFF : ST_RELEASE;
        cnt_n = want == NONE ? 8'd0 : hold;
      end
      ST_RELEASE: begin
        cnt_n = cnt - 8'd1;
        state_n = cnt == 8'd1 ? ST_RUN : ST_RELEASE;
      end
      default: state_n = ST_OFF;
    endcase
  end
  // sequencer state, counter and active selection
  always_ff @(posedge wb_clk_i or negedge rst_n)
    if (!rst_n) begin
      state <= ST_OFF;
      cnt <= '0;
      active_sel <= NONE;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      active_sel <= sel_n;
    end
  assign design_rst_n = state == ST_RUN ? rst_mask(active_sel) : 3'b000;
  assign busy = state != ST_RUN && state != ST_OFF;
endmodule

// File: tb/tb_design_reset_sequencer.sv
// tb_design_reset_sequencer: randomized self-checking bench against a timing/register model
module tb_design_reset_sequencer;
  import design_mux_pkg::*;
  localparam logic [31:0] BASE = 32'h3000_0000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] design_rst_n;
  logic [1:0] active_sel;
  logic [31:0] custom_settings;
  logic busy;
  int total = 0;
  int bad = 0;
  int m_hold = 16;
  int m_active = 3;
  logic [31:0] m_settings = '0;
  design_reset_sequencer_if bus();
  always #5 clk = ~clk;
  design_reset_sequencer dut (
    .wb_clk_i(clk),
    .rst_n(rst_n),
    .wbs_cyc_i(bus.cyc),
    .wbs_stb_i(bus.stb),
    .wbs_we_i(bus.we),
    .wbs_adr_i(bus.adr),
    .wbs_dat_i(bus.dat_w),
    .wbs_ack_o(bus.ack),
    .wbs_dat_o(bus.dat_r),
    .design_rst_n(design_rst_n),
    .active_sel(active_sel),
    .custom_settings(custom_settings),
    .busy(busy)
  );

  function automatic logic [2:0] exp_mask(input int sel);
    return sel == 3 ? 3'd0 : 3'(1 << sel);
  endfunction

  function automatic logic [31:0] exp_status(input int st, input int sel, input int cnt);
    return 32'(cnt * 256 + sel * 8 + st);
  endfunction

  task automatic bus_idle();
    bus.cyc = 0; bus.stb = 0; bus.we = 0; bus.adr = '0; bus.dat_w = '0;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    bit got = 0;
    @(posedge clk); #1;
    bus.cyc = 1; bus.stb = 1; bus.we = 1; bus.adr = a; bus.dat_w = d;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      got = bus.ack;
    end
    bus_idle();
    total++;
    if (!got) begin bad++; $display("FAIL wb_write_ack adr=%h got=0 want=1", a); end
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    bit got = 0;
    d = 'x;
    @(posedge clk); #1;
    bus.cyc = 1; bus.stb = 1; bus.we = 0; bus.adr = a;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (bus.ack) begin got = 1; d = bus.dat_r; end
    end
    bus_idle();
    total++;
    if (!got) begin bad++; $display("FAIL wb_read_ack adr=%h got=0 want=1", a); end
  endtask

  task automatic measure(input logic [2:0] mask, input int limit, output int n, output bit clean);
    n = 0;
    clean = 1;
    while (n < limit) begin
      @(posedge clk); #1;
      n++;
      if (design_rst_n === mask) break;
      if (design_rst_n !== 3'b000) clean = 0;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_n = 0;
    bus_idle();
    repeat (3) @(posedge clk);
    #1;
    total++; if (design_rst_n !== 3'b000) begin bad++; $display("FAIL reset_rst got=%b want=000", design_rst_n); end
    total++; if (active_sel !== 2'd3) begin bad++; $display("FAIL reset_sel got=%0d want=3", active_sel); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (custom_settings !== 32'd0) begin bad++; $display("FAIL reset_settings got=%h want=0", custom_settings); end
    total++; if (bus.ack !== 1'b0 || bus.dat_r !== 32'd0) begin bad++; $display("FAIL reset_bus ack=%b dat=%h want 0/0", bus.ack, bus.dat_r); end
    @(negedge clk) rst_n = 1;
    wb_read(BASE + 12, d);
    total++; if (d !== 32'(m_hold)) begin bad++; $display("FAIL reset_hold got=%0d want=%0d", d, m_hold); end
    wb_read(BASE + 8, d);
    total++; if (d !== exp_status(int'(ST_OFF), 3, 0)) begin bad++; $display("FAIL reset_status got=%h want=%h", d, exp_status(int'(ST_OFF), 3, 0)); end
    wb_read(BASE, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL reset_ctrl got=%h want=0", d); end
  endtask

  task automatic test_enable_from_off();
    int n;
    bit clean;
    logic [31:0] d;
    wb_write(BASE, 32'h6);
    measure(exp_mask(2), m_hold + 40, n, clean);
    total++; if (n !== m_hold + 2) begin bad++; $display("FAIL off_latency got=%0d want=%0d", n, m_hold + 2); end
    total++; if (!clean) begin bad++; $display("FAIL off_clean got=glitch want=000"); end
    total++; if (active_sel !== 2'd2 || design_rst_n !== 3'b100) begin bad++; $display("FAIL off_sel got=%0d/%b want=2/100", active_sel, design_rst_n); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL off_busy got=%b want=0", busy); end
    m_active = 2;
    wb_read(BASE + 8, d);
    total++; if (d !== exp_status(int'(ST_RUN), 2, 0)) begin bad++; $display("FAIL off_status got=%h want=%h", d, exp_status(int'(ST_RUN), 2, 0)); end
  endtask

  task automatic test_switch_hold4();
    int n;
    bit clean;
    wb_write(BASE + 12, 4);
    m_hold = 4;
    wb_write(BASE, 32'h4);
    measure(exp_mask(0), 60, n, clean);
    total++; if (n !== 2 * m_hold + 2) begin bad++; $display("FAIL switch_latency got=%0d want=%0d", n, 2 * m_hold + 2); end
    total++; if (!clean) begin bad++; $display("FAIL switch_clean got=glitch want=000"); end
    total++; if (active_sel !== 2'd0) begin bad++; $display("FAIL switch_sel got=%0d want=0", active_sel); end
    m_active = 0;
  endtask

  task automatic test_hold_zero();
    int n;
    bit clean;
    wb_write(BASE + 12, 0);
    m_hold = 1;
    wb_write(BASE, 32'h5);
    measure(exp_mask(1), 40, n, clean);
    total++; if (n !== 4) begin bad++; $display("FAIL hold0_latency got=%0d want=4", n); end
    total++; if (!clean || active_sel !== 2'd1) begin bad++; $display("FAIL hold0_sel got=%0d clean=%b want=1/1", active_sel, clean); end
    m_active = 1;
  endtask

  task automatic test_settings();
    logic [31:0] d;
    logic [3:0] acks;
    int cnt;
    wb_write(BASE + 4, 32'hDEAD_BEEF);
    m_settings = 32'hDEAD_BEEF;
    total++; if (custom_settings !== m_settings) begin bad++; $display("FAIL settings_out got=%h want=%h", custom_settings, m_settings); end
    wb_read(BASE + 4, d);
    total++; if (d !== m_settings) begin bad++; $display("FAIL settings_read got=%h want=%h", d, m_settings); end
    @(posedge clk); #1;
    bus.cyc = 1; bus.stb = 1; bus.we = 0; bus.adr = BASE + 4;
    for (int i = 3; i >= 0; i--) begin @(posedge clk); #1; acks[i] = bus.ack; end
    bus_idle();
    total++; if (acks !== 4'b1010) begin bad++; $display("FAIL held_stb_ack got=%b want=1010", acks); end
    cnt = 0;
    @(posedge clk); #1;
    bus.cyc = 1; bus.stb = 1; bus.we = 1; bus.adr = BASE + 16; bus.dat_w = 32'h1234_5678;
    repeat (4) begin @(posedge clk); #1; cnt += int'(bus.ack); end
    bus.adr = 32'h2000_0004;
    repeat (4) begin @(posedge clk); #1; cnt += int'(bus.ack); end
    bus_idle();
    total++; if (cnt !== 0) begin bad++; $display("FAIL miss_ack got=%0d want=0", cnt); end
    total++; if (custom_settings !== m_settings) begin bad++; $display("FAIL miss_write got=%h want=%h", custom_settings, m_settings); end
    wb_write(BASE + 8, 32'hFFFF_FFFF);
    wb_read(BASE + 8, d);
    total++; if (d !== exp_status(int'(ST_RUN), m_active, 0)) begin bad++; $display("FAIL status_ro got=%h want=%h", d, exp_status(int'(ST_RUN), m_active, 0)); end
  endtask

  task automatic test_random();
    int h, want, n, lat;
    bit clean, en;
    logic [1:0] tgt;
    logic [31:0] d;
    for (int k = 0; k < 14; k++) begin
      h = $urandom_range(0, 5);
      wb_write(BASE + 12, 32'(h));
      m_hold = h == 0 ? 1 : h;
      tgt = 2'($urandom_range(0, 3));
      en = $urandom_range(0, 3) != 0;
      wb_write(BASE, 32'({en, tgt}));
      want = (en && tgt != 2'd3) ? int'(tgt) : 3;
      if (want == m_active) begin
        repeat (2 * m_hold + 4) @(posedge clk);
        #1;
        total++; if (design_rst_n !== exp_mask(m_active) || busy !== 1'b0) begin bad++; $display("FAIL rnd_stay k=%0d got=%b/%b want=%b/0", k, design_rst_n, busy, exp_mask(m_active)); end
      end else if (want == 3) begin
        clean = 1;
        repeat (m_hold + 3) begin @(posedge clk); #1; if (design_rst_n !== 3'b000) clean = 0; end
        wb_read(BASE + 8, d);
        total++; if (!clean || d !== exp_status(int'(ST_OFF), 3, 0)) begin bad++; $display("FAIL rnd_off k=%0d got=%h clean=%b want=%h", k, d, clean, exp_status(int'(ST_OFF), 3, 0)); end
      end else begin
        lat = m_active == 3 ? m_hold + 2 : 2 * m_hold + 2;
        measure(exp_mask(want), lat + 20, n, clean);
        total++; if (n !== lat || !clean) begin bad++; $display("FAIL rnd_latency k=%0d got=%0d clean=%b want=%0d", k, n, clean, lat); end
        total++; if (active_sel !== 2'(want)) begin bad++; $display("FAIL rnd_sel k=%0d got=%0d want=%0d", k, active_sel, want); end
      end
      m_active = want;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    @(posedge clk); #1 rst_n = 0;
    #2 rst_n = 1;
    m_active = 3;
    m_hold = 16;
    wb_write(BASE + 4, 32'hA5A5_5A5A);
    wb_write(BASE + 12, 8);
    wb_write(BASE, 32'h5);
    repeat (4) @(posedge clk);
    #1;
    total++; if (busy !== 1'b1 || active_sel !== 2'd1) begin bad++; $display("FAIL mid_pre got=%b/%0d want=1/1", busy, active_sel); end
    #2 rst_n = 0;
    #1;
    total++; if (design_rst_n !== 3'b000 || active_sel !== 2'd3 || busy !== 1'b0) begin bad++; $display("FAIL mid_async got=%b/%0d/%b want=000/3/0", design_rst_n, active_sel, busy); end
    total++; if (custom_settings !== 32'd0) begin bad++; $display("FAIL mid_settings got=%h want=0", custom_settings); end
    @(negedge clk) rst_n = 1;
    wb_read(BASE + 12, d);
    total++; if (d !== 32'(m_hold)) begin bad++; $display("FAIL mid_hold got=%0d want=%0d", d, m_hold); end
    wb_read(BASE, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL mid_ctrl got=%h want=0", d); end
    wb_read(BASE + 8, d);
    total++; if (d !== exp_status(int'(ST_OFF), 3, 0)) begin bad++; $display("FAIL mid_status got=%h want=%h", d, exp_status(int'(ST_OFF), 3, 0)); end
    repeat (30) @(posedge clk);
    #1;
    total++; if (design_rst_n !== 3'b000 || busy !== 1'b0) begin bad++; $display("FAIL mid_quiet got=%b/%b want=000/0", design_rst_n, busy); end
  endtask

  initial begin
    bus_idle();
    test_reset();
    test_enable_from_off();
    test_switch_hold4();
    test_hold_zero();
    test_settings();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
